// File: rtl/mips_debug_top.sv
`default_nettype none
// mips_debug_top: UART-driven debug shell that loads a program into IMEM,
// sequences the PC in run or single-step mode and reports PC/cycles/instruction.
module mips_debug_top #(
   parameter int NB_DATA    = 32,
   parameter int NB_BYTE    = 8,
   parameter int TICK_DIV   = 651,
   parameter int IMEM_DEPTH = 64
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_Rx,
   input  logic         i_test,
   output logic         o_Tx,
   output logic         o_programa_cargado,
   output logic         o_programa_no_cargado,
   output logic         o_programa_terminado,
   output logic [7:0]   o_leds,
   output logic         o_test
);
   localparam int AW        = $clog2(IMEM_DEPTH);
   localparam int LW        = AW + 1;
   localparam int TW        = $clog2(TICK_DIV + 1);
   localparam int BITW      = $clog2(NB_BYTE);
   localparam int BPW       = NB_DATA / NB_BYTE;
   localparam int BCW       = $clog2(BPW);
   localparam int REP_W     = 3 * NB_DATA;
   localparam int REP_BYTES = REP_W / NB_BYTE;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_STEP = 3'd3, S_REPORT = 3'd4
   } dbg_state_e;

   // ---------------- baud tick and input synchronizers ----------------
   logic [TW-1:0] tick_cnt_q;
   logic          w_tick;
   logic          rx_meta_q, rx_sync_q, test_meta_q, test_q;

   assign w_tick = (tick_cnt_q == TW'(TICK_DIV - 1));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         tick_cnt_q  <= '0;
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         test_meta_q <= 1'b0;
         test_q      <= 1'b0;
      end else begin
         tick_cnt_q  <= w_tick ? '0 : tick_cnt_q + TW'(1);
         rx_meta_q   <= i_Rx;
         rx_sync_q   <= rx_meta_q;
         test_meta_q <= i_test;
         test_q      <= test_meta_q;
      end
   end

   // ---------------- UART receiver ----------------
   rx_state_e          rx_state_q, rx_state_d;
   logic [3:0]         rx_tcnt_q, rx_tcnt_d;
   logic [BITW-1:0]    rx_bit_q, rx_bit_d;
   logic [NB_BYTE-1:0] rx_shift_q, rx_shift_d;
   logic               rx_valid_q, rx_valid_d;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_tcnt_d  = rx_tcnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (!rx_sync_q) begin
            rx_state_d = RX_START;
            rx_tcnt_d  = '0;
         end
         RX_START: if (w_tick) begin
            // Mid-start sample: a line already back high was only a glitch.
            if (rx_tcnt_q == 4'd7) begin
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
               rx_tcnt_d  = '0;
               rx_bit_d   = '0;
            end else begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
         end
         RX_DATA: if (w_tick) begin
            if (rx_tcnt_q == 4'd15) begin
               rx_tcnt_d  = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[NB_BYTE-1:1]};
               if (rx_bit_q == BITW'(NB_BYTE - 1)) rx_state_d = RX_STOP;
               else rx_bit_d = rx_bit_q + BITW'(1);
            end else begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
         end
         RX_STOP: if (w_tick) begin
            if (rx_tcnt_q == 4'd15) begin
               rx_state_d = RX_IDLE;
               rx_valid_d = rx_sync_q;
            end else begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rx_state_q <= RX_IDLE;
         rx_tcnt_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // ---------------- UART transmitter ----------------
   tx_state_e          tx_state_q, tx_state_d;
   logic [3:0]         tx_tcnt_q, tx_tcnt_d;
   logic [BITW-1:0]    tx_bit_q, tx_bit_d;
   logic [NB_BYTE-1:0] tx_shift_q, tx_shift_d;
   logic               tx_q, tx_d;
   logic               w_tx_start;
   logic [NB_BYTE-1:0] w_tx_byte;
   logic               w_tx_busy;

   assign w_tx_busy = (tx_state_q != TX_IDLE);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_tcnt_d  = tx_tcnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (w_tx_start) begin
               tx_state_d = TX_START;
               tx_shift_d = w_tx_byte;
               tx_tcnt_d  = '0;
               tx_d       = 1'b0;
            end
         end
         TX_START: if (w_tick) begin
            if (tx_tcnt_q == 4'd15) begin
               tx_state_d = TX_DATA;
               tx_tcnt_d  = '0;
               tx_bit_d   = '0;
               tx_d       = tx_shift_q[0];
            end else begin
               tx_tcnt_d = tx_tcnt_q + 4'd1;
            end
         end
         TX_DATA: if (w_tick) begin
            if (tx_tcnt_q == 4'd15) begin
               tx_tcnt_d = '0;
               if (tx_bit_q == BITW'(NB_BYTE - 1)) begin
                  tx_state_d = TX_STOP;
                  tx_d       = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + BITW'(1);
                  tx_shift_d = {1'b0, tx_shift_q[NB_BYTE-1:1]};
                  tx_d       = tx_shift_q[1];
               end
            end else begin
               tx_tcnt_d = tx_tcnt_q + 4'd1;
            end
         end
         TX_STOP: if (w_tick) begin
            if (tx_tcnt_q == 4'd15) tx_state_d = TX_IDLE;
            else tx_tcnt_d = tx_tcnt_q + 4'd1;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         tx_state_q <= TX_IDLE;
         tx_tcnt_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   // ---------------- debug unit, IMEM and PC sequencer ----------------
   dbg_state_e          state_q, state_d, ret_q, ret_d;
   logic [NB_DATA-1:0]  pc_q, pc_d, cyc_q, cyc_d, word_q, word_d;
   logic [LW-1:0]       len_q, len_d;
   logic                cargado_q, cargado_d, term_q, term_d;
   logic [BCW-1:0]      bcnt_q, bcnt_d;
   logic [3:0]          idx_q, idx_d;
   logic [NB_DATA-1:0]  imem_q [IMEM_DEPTH];
   logic                w_we;
   logic [AW-1:0]       w_waddr;
   logic [NB_DATA-1:0]  w_word_next, w_pc_next, w_instr;
   logic [NB_DATA-3:0]  w_len_ext;
   logic                w_hit;
   logic [REP_W-1:0]    w_rep;

   assign w_word_next = {word_q[NB_DATA-NB_BYTE-1:0], rx_shift_q};
   assign w_len_ext   = (NB_DATA-2)'(len_q);
   assign w_pc_next   = pc_q + NB_DATA'(4);
   assign w_hit       = (w_pc_next[NB_DATA-1:2] == w_len_ext);
   assign w_instr     = (pc_q[NB_DATA-1:2] < w_len_ext) ? imem_q[pc_q[AW+1:2]] : '0;
   assign w_rep       = {pc_q, cyc_q, w_instr};
   assign w_tx_byte   = w_rep[REP_W - 1 - NB_BYTE * int'(idx_q) -: NB_BYTE];

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      pc_d       = pc_q;
      cyc_d      = cyc_q;
      word_d     = word_q;
      len_d      = len_q;
      cargado_d  = cargado_q;
      term_d     = term_q;
      bcnt_d     = bcnt_q;
      idx_d      = idx_q;
      w_we       = 1'b0;
      w_waddr    = len_q[AW-1:0];
      w_tx_start = 1'b0;
      case (state_q)
         S_IDLE: if (rx_valid_q) begin
            idx_d = '0;
            case (rx_shift_q)
               8'h4C: begin
                  state_d   = S_LOAD;
                  len_d     = '0;
                  pc_d      = '0;
                  cyc_d     = '0;
                  term_d    = 1'b0;
                  cargado_d = 1'b0;
                  bcnt_d    = '0;
               end
               8'h45: if (cargado_q && !term_q) state_d = S_RUN;
               8'h53: if (cargado_q) state_d = S_STEP;
               8'h4D: begin
                  state_d = S_REPORT;
                  ret_d   = S_IDLE;
               end
               default: ;
            endcase
         end
         S_LOAD: if (rx_valid_q) begin
            word_d = w_word_next;
            bcnt_d = bcnt_q + BCW'(1);
            if (bcnt_q == BCW'(BPW - 1)) begin
               if (w_word_next == {NB_DATA{1'b1}}) begin
                  state_d   = S_IDLE;
                  cargado_d = (len_q != '0);
               end else if (len_q < LW'(IMEM_DEPTH)) begin
                  w_we  = 1'b1;
                  len_d = len_q + LW'(1);
               end
            end
         end
         S_RUN: begin
            pc_d  = w_pc_next;
            cyc_d = cyc_q + NB_DATA'(1);
            if (w_hit) begin
               term_d  = 1'b1;
               state_d = S_REPORT;
               ret_d   = S_IDLE;
               idx_d   = '0;
            end
         end
         S_STEP: if (rx_valid_q) begin
            if (rx_shift_q == 8'h01) begin
               if (!term_q) begin
                  pc_d  = w_pc_next;
                  cyc_d = cyc_q + NB_DATA'(1);
                  if (w_hit) term_d = 1'b1;
               end
               state_d = S_REPORT;
               ret_d   = S_STEP;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REPORT: if (!w_tx_busy) begin
            // The transmitter turns busy on the cycle after a start, so one byte per idle window.
            if (idx_q == 4'(REP_BYTES)) begin
               state_d = ret_q;
            end else begin
               w_tx_start = 1'b1;
               idx_d      = idx_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= S_IDLE;
         ret_q     <= S_IDLE;
         pc_q      <= '0;
         cyc_q     <= '0;
         word_q    <= '0;
         len_q     <= '0;
         cargado_q <= 1'b0;
         term_q    <= 1'b0;
         bcnt_q    <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         pc_q      <= pc_d;
         cyc_q     <= cyc_d;
         word_q    <= word_d;
         len_q     <= len_d;
         cargado_q <= cargado_d;
         term_q    <= term_d;
         bcnt_q    <= bcnt_d;
         idx_q     <= idx_d;
      end
   end

   // Program memory keeps its contents across reset.
   always_ff @(posedge i_clk) begin
      if (w_we) imem_q[w_waddr] <= w_word_next;
   end

   assign o_Tx                  = tx_q;
   assign o_programa_cargado    = cargado_q;
   assign o_programa_no_cargado = ~cargado_q;
   assign o_programa_terminado  = term_q;
   assign o_leds                = {state_q, term_q, cargado_q, (rx_state_q != RX_IDLE), w_tx_busy, 1'b0};
   assign o_test                = test_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_debug_top.sv
`default_nettype none
// tb_mips_debug_top: directed serial-level checks of the MIPS debug shell.
module tb_mips_debug_top;
   localparam int TICK_DIV = 2;
   localparam int BIT_CYC  = 16 * TICK_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        test_in = 1'b0;
   wire         tx, cargado, no_cargado, terminado, test_out;
   wire  [7:0]  leds;
   logic [95:0] rep;
   int          n_cmp = 0;
   int          n_err = 0;

   mips_debug_top #(.NB_DATA(32), .NB_BYTE(8), .TICK_DIV(TICK_DIV), .IMEM_DEPTH(64)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_Rx(rx), .i_test(test_in),
      .o_Tx(tx), .o_programa_cargado(cargado), .o_programa_no_cargado(no_cargado),
      .o_programa_terminado(terminado), .o_leds(leds), .o_test(test_out)
   );

   always #5 clk = ~clk;

   initial begin
      #(10 * 150000);
      $display("FAIL watchdog: observed hang, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx = 1'b0;
      wait_cyc(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(BIT_CYC);
      end
      rx = 1'b1;
      wait_cyc(BIT_CYC);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   task automatic recv_byte(output logic [7:0] b);
      int t = 0;
      b = 'x;
      while (tx !== 1'b0 && t < 4000) begin
         wait_cyc(1);
         t++;
      end
      if (tx === 1'b0) begin
         wait_cyc(BIT_CYC / 2);
         for (int i = 0; i < 8; i++) begin
            wait_cyc(BIT_CYC);
            b[i] = tx;
         end
         wait_cyc(BIT_CYC);
      end
   endtask

   task automatic recv_report();
      logic [7:0] b;
      rep = '0;
      for (int k = 0; k < 12; k++) begin
         recv_byte(b);
         rep = {rep[87:0], b};
      end
   endtask

   task automatic cmd_report(input logic [7:0] cmd);
      fork
         send_byte(cmd);
         recv_report();
      join
   endtask

   initial begin
      // Reset values
      wait_cyc(5);
      check("rst_tx", tx, 1);
      check("rst_no_cargado", no_cargado, 1);
      check("rst_cargado", cargado, 0);
      check("rst_terminado", terminado, 0);
      check("rst_leds", leds, 8'h00);
      rst_n = 1'b1;
      wait_cyc(3);

      // o_test two-flop latency
      test_in = 1'b1;
      wait_cyc(1);
      check("test_lat1", test_out, 0);
      wait_cyc(1);
      check("test_lat2", test_out, 1);

      // Report with no program
      cmd_report(8'h4D);
      check("rep_empty", rep, 96'h0);
      check("empty_cargado", cargado, 0);

      // Load two words
      send_byte(8'h4C);
      send_word(32'hAABBCCDD);
      send_word(32'h11223344);
      send_word(32'hFFFFFFFF);
      wait_cyc(4);
      check("load_cargado", cargado, 1);
      check("load_no_cargado", no_cargado, 0);
      cmd_report(8'h4D);
      check("rep_loaded", rep, 96'h00000000_00000000_AABBCCDD);
      wait_cyc(40);
      check("leds_idle_loaded", leds, 8'h08);

      // Single stepping
      send_byte(8'h53);
      wait_cyc(4);
      check("leds_step", leds, 8'h68);
      cmd_report(8'h01);
      check("rep_step1", rep, 96'h00000004_00000001_11223344);
      check("step1_terminado", terminado, 0);
      cmd_report(8'h01);
      check("rep_step2", rep, 96'h00000008_00000002_00000000);
      check("step2_terminado", terminado, 1);
      wait_cyc(40);
      check("leds_step_term", leds, 8'h78);
      send_byte(8'h00);
      wait_cyc(4);
      check("leds_back_idle", leds, 8'h18);

      // Reload three words and run
      send_byte(8'h4C);
      send_word(32'h01020304);
      send_word(32'h05060708);
      send_word(32'h090A0B0C);
      send_word(32'hFFFFFFFF);
      wait_cyc(4);
      check("reload_terminado", terminado, 0);
      check("reload_cargado", cargado, 1);
      cmd_report(8'h45);
      check("rep_run", rep, 96'h0000000C_00000003_00000000);
      check("run_terminado", terminado, 1);
      wait_cyc(40);

      // Short low glitch on the serial line
      rx = 1'b0;
      wait_cyc(6);
      rx = 1'b1;
      wait_cyc(3);
      check("glitch_rx_busy", leds[2], 1);
      wait_cyc(40);
      check("glitch_rejected", leds, 8'h18);

      // Reset in the middle of a report frame
      send_byte(8'h4D);
      for (int t = 0; t < 200 && tx !== 1'b0; t++) wait_cyc(1);
      wait_cyc(40);
      check("midtx_tx_low", tx, 0);
      check("midtx_leds", leds, 8'h9A);
      rst_n = 1'b0;
      #1;
      check("arst_tx", tx, 1);
      check("arst_leds", leds, 8'h00);
      check("arst_cargado", cargado, 0);
      check("arst_no_cargado", no_cargado, 1);
      check("arst_terminado", terminado, 0);
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(3);
      cmd_report(8'h4D);
      check("rep_after_reset", rep, 96'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mips_debug_top.md
Name: mips_debug_top

Overview:
- Top-level debug shell of the MIPS project.
- Contains a UART receiver/transmitter (8N1), a command-decoding debug unit, a program instruction memory and a minimal PC-sequencer execution core.
- A host loads a program, runs it continuously or step by step, and reads back the execution state over the serial line.
- Status flags drive board LEDs.

Parameters:
NB_DATA, 32, data/instruction/PC width
NB_BYTE, 8, UART frame data width
TICK_DIV, 651, i_clk cycles per 16x-oversample baud tick (100 MHz / 9600 baud)
IMEM_DEPTH, 64, instruction memory words (power of two)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset  input  1  asynchronous active-low reset
i_Rx  input  1  UART serial in, idle high
i_test  input  1  test input
o_Tx  output  1  UART serial out, idle high
o_programa_cargado  output  1  program loaded flag
o_programa_no_cargado  output  1  always the inverse of o_programa_cargado
o_programa_terminado  output  1  execution reached end of program
o_leds  output  8  debug state display
o_test  output  1  i_test passed through a 2-flop synchronizer

Behaviour:
- Reset (i_reset=0, asynchronous) sets:
  - o_Tx=1.
  - All flags 0, so o_programa_no_cargado=1.
  - PC=0, cycle count=0, program length=0.
  - FSM to IDLE, o_leds=0.
  - IMEM contents are not cleared.
  - Reset mid-frame or mid-load aborts everything.
- UART RX:
  - 16x oversampling; start bit is confirmed at tick 7 after the falling edge, otherwise rejected as a glitch.
  - Data bits are sampled every 16 ticks, LSB first.
  - Stop bit must be 1, otherwise the byte is dropped.
  - Each accepted byte produces a 1-cycle rx_valid.
- UART TX:
  - 8N1, LSB first, 16 ticks per bit.
  - Bytes come from a send queue driven by the FSM; the next byte starts only after the previous stop bit completes.
- FSM states: IDLE, LOAD, RUN, STEP, REPORT. Commands are accepted in IDLE only; unknown bytes are ignored.
- 'L' (0x4C) enters LOAD:
  - Bytes are assembled MSB-first into 32-bit words.
  - Word 0xFFFFFFFF terminates the load and is not stored. Length = number of words stored; o_programa_cargado=1 if length>0.
  - Words beyond IMEM_DEPTH are discarded, but the terminator is still awaited.
  - A new 'L' overwrites the program and resets PC, cycle count and terminado.
- 'E' (0x45), program loaded and not terminated:
  - RUN: one step per clock until halt, then REPORT.
- 'S' (0x53), program loaded:
  - Enters STEP.
  - Byte 0x01 executes one step, then REPORT, then returns to STEP.
  - Any other byte returns to IDLE.
  - A step while terminated does nothing except REPORT.
- 'M' (0x4D): REPORT immediately from IDLE.
- Execution step:
  - PC += 4, cycle count += 1 (wraps at 2^32).
  - When PC/4 == length, o_programa_terminado=1 and the core freezes.
- REPORT:
  - Transmits 12 bytes, each value MSB first: PC, cycle count, IMEM[PC/4] (0 if PC/4 >= length).
  - Returns to the originating state (IDLE or STEP).
  - Received bytes are ignored during REPORT.
- o_leds = {state[2:0], terminado, cargado, rx_busy, tx_busy, 1'b0}.
- o_test follows i_test with 2-cycle latency.

Test Plan:
- Reset → o_Tx=1, o_programa_no_cargado=1, o_programa_cargado=0, o_programa_terminado=0; o_test follows i_test 2 cycles after a toggle.
- Send 'M' with no program → 12 bytes returned, all 0x00; flags unchanged.
- Send 'L', AABBCCDD, 11223344, FFFFFFFF → o_programa_cargado=1; then 'M' returns 00000000 00000000 AABBCCDD.
- After the previous load: 'S', 0x01 → report 00000004 00000001 11223344. Second 0x01 → 00000008 00000002 00000000, o_programa_terminado=1.
- Load 3 words, then 'E' → one report 0000000C 00000003 00000000, o_programa_terminado=1.
- Glitch: a 3-tick low pulse on i_Rx produces no byte. Assert reset during a TX frame → o_Tx returns to 1 immediately and all state clears.
